// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the LFSR countdown timer.
//   lfsr_state_t  : controller state (IDLE, RUN)
//   lfsr_step     : one forward step of the XNOR Galois LFSR
//   lfsr_seed_for : n steps backwards from a target state (seed planning)
// The helpers operate on a fixed 32-bit container; only the low `size` bits
// are meaningful, which lets one function serve any LFSR width.
package lfsr_pkg;

  typedef enum logic {IDLE, RUN} lfsr_state_t;

  localparam int LFSR_MAX_W = 32;
  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  // Shift toward bit 0; the bit falling out of stage 0 feeds stage size-1
  // and, through XNOR, every stage whose poly bit is set.
  function automatic lfsr_word_t lfsr_step(input lfsr_word_t state,
                                           input lfsr_word_t poly,
                                           input int size);
    lfsr_word_t nxt;
    logic fb;
    nxt = '0;
    fb  = state[0];
    for (int i = 1; i < LFSR_MAX_W; i++) begin
      if (i < size) nxt[i-1] = poly[i-1] ? ~(state[i] ^ fb) : state[i];
    end
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if (i == size - 1) nxt[i] = fb;
    end
    return nxt;
  endfunction

  // Inverse of lfsr_step applied n times: the top stage of the successor
  // is the old stage 0, which recovers fb and hence every other stage.
  function automatic lfsr_word_t lfsr_seed_for(input int n,
                                               input lfsr_word_t poly,
                                               input lfsr_word_t terminal,
                                               input int size);
    lfsr_word_t cur;
    lfsr_word_t prev;
    logic fb;
    cur = terminal;
    for (int k = 0; k < n; k++) begin
      fb = 1'b0;
      for (int i = 0; i < LFSR_MAX_W; i++) begin
        if (i == size - 1) fb = cur[i];
      end
      prev    = '0;
      prev[0] = fb;
      for (int i = 1; i < LFSR_MAX_W; i++) begin
        if (i < size) prev[i] = poly[i-1] ? (~cur[i-1] ^ fb) : cur[i-1];
      end
      cur = prev;
    end
    return cur;
  endfunction

endpackage

// File: rtl/lfsr_timer_if.sv
// lfsr_timer_if: control/status bundle between the tick/control side and
// the LFSR timer.
//   i_enable, i_load, i_seed, i_periodic, i_stop : driven by the controller
//   o_busy, o_done, o_error, o_sreg               : driven by the timer
interface lfsr_timer_if #(
  parameter int SIZE = 16
);
  logic            i_enable;
  logic            i_load;
  logic [SIZE-1:0] i_seed;
  logic            i_periodic;
  logic            i_stop;
  logic            o_busy;
  logic            o_done;
  logic            o_error;
  logic [SIZE-1:0] o_sreg;

  modport master (
    output i_enable, i_load, i_seed, i_periodic, i_stop,
    input  o_busy, o_done, o_error, o_sreg
  );

  modport slave (
    input  i_enable, i_load, i_seed, i_periodic, i_stop,
    output o_busy, o_done, o_error, o_sreg
  );
endinterface

// File: rtl/lfsr_timer.sv
// lfsr_timer: countdown timer built on an XNOR Galois LFSR.
// A load arms the timer with a seed; the LFSR steps on enabled cycles until
// it reaches TERMINAL, then o_done pulses and the timer either stops or
// reloads the seed (periodic mode). The all-ones seed is the XNOR lock-up
// state and is rejected with a sticky o_error.
// Ports:
//   clock    : rising-edge clock
//   i_reset  : synchronous active-high reset
//   bus      : lfsr_timer_if slave (enable/load/seed/periodic/stop in;
//              busy/done/error/sreg out)
module lfsr_timer
  import lfsr_pkg::*;
#(
  parameter lfsr_word_t POLY     = 32'b1101_0000_0000_1000,
  parameter lfsr_word_t TERMINAL = '0
) (
  input logic         clock,
  input logic         i_reset,
  lfsr_timer_if.slave bus
);

  localparam int SIZE = $clog2(POLY);
  localparam logic [SIZE-1:0] TERM_S = TERMINAL[SIZE-1:0];

  if (SIZE < 2) begin : g_bad_size
    $error("lfsr_timer: POLY gives an LFSR narrower than 2 bits");
  end

  lfsr_state_t     state_q, state_d;
  logic [SIZE-1:0] sreg_q, sreg_d;
  logic [SIZE-1:0] seed_q, seed_d;
  logic            mode_q, mode_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  lfsr_word_t      step_w;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      seed_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      seed_q  <= seed_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    seed_d  = seed_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    error_d = error_q;
    step_w  = lfsr_step(LFSR_MAX_W'(sreg_q), POLY, SIZE);

    if (bus.i_stop) begin
      state_d = IDLE;
    end else if (bus.i_load) begin
      if (&bus.i_seed) begin
        // Lock-up seed: never enters the LFSR; a running count is abandoned.
        error_d = 1'b1;
        state_d = IDLE;
      end else begin
        sreg_d  = bus.i_seed;
        seed_d  = bus.i_seed;
        mode_d  = bus.i_periodic;
        error_d = 1'b0;
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      // Terminal wins over enable so a zero-length count expires at once.
      if (sreg_q == TERM_S) begin
        done_d = 1'b1;
        if (mode_q) sreg_d = seed_q;
        else        state_d = IDLE;
      end else if (bus.i_enable) begin
        sreg_d = step_w[SIZE-1:0];
      end
    end
  end

  assign bus.o_busy  = (state_q == RUN);
  assign bus.o_done  = done_q;
  assign bus.o_error = error_q;
  assign bus.o_sreg  = sreg_q;

endmodule

// File: doc/lfsr_timer.md
# lfsr_timer

- Programmable countdown timer built on a parametrised Galois LFSR with XNOR taps.
- Software loads a seed state; the timer steps the LFSR on qualified ticks until it hits the TERMINAL state, then emits a done pulse and either stops (one-shot) or reloads the seed (periodic).
- Adds load, periodic mode, abort, and lock-up detection, which the plain LFSR core lacks.
- Sits between a tick source (prescaler/strobe) and the control logic that consumes expiry events.

## Interface
- POLY, 16'b1101_0000_0000_1000, feedback polynomial; bit i set = tap into stage i.
- SIZE, $clog2(POLY) (localparam), LFSR width; must be >= 2 (elaboration assertion).
- TERMINAL, '0 (SIZE bits), state at which the count expires.

- clock  in  1  clock, rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_enable  in  1  step qualifier; LFSR advances only when high in RUN.
- i_load  in  1  capture i_seed/i_periodic and arm.
- i_seed  in  SIZE  start state.
- i_periodic  in  1  mode, sampled with i_load: 1 = auto-reload.
- i_stop  in  1  abort count, return to IDLE.
- o_busy  out  1  high while state == RUN.
- o_done  out  1  one-cycle registered expiry pulse.
- o_error  out  1  last load used the lock-up seed; sticky.
- o_sreg  out  SIZE  current LFSR state.

## Operation
- Step function, shift toward bit 0, fb = sreg[0]:
  - next[SIZE-1] = fb.
  - next[i-1] = POLY[i-1] ? ~(sreg[i]^fb) : sreg[i], for i = 1..SIZE-1.
- All-ones is the XNOR lock-up state. A load with i_seed == all-ones is rejected.
- States: IDLE, RUN.
- IDLE:
  - sreg holds.
  - i_load with a legal seed: sreg <= i_seed, seed_reg <= i_seed, mode_reg <= i_periodic, o_error <= 0, go to RUN.
  - i_load with the all-ones seed: o_error <= 1; sreg, seed_reg and state unchanged.
- RUN, evaluated each cycle in priority order:
  1. sreg == TERMINAL: o_done <= 1. If mode_reg, sreg <= seed_reg and stay in RUN; otherwise go to IDLE with sreg holding TERMINAL. The terminal check ignores i_enable.
  2. Else if i_enable: sreg <= step(sreg).
  3. Else hold.
- Priority: i_reset > i_stop > i_load > RUN/IDLE behaviour.
- i_stop in any state: go to IDLE, sreg frozen, no o_done, o_error unchanged.
- i_load during RUN re-arms from i_seed (same legality check). A pending terminal in that cycle produces no o_done. An illegal seed in RUN sets o_error, forces IDLE, and freezes sreg.
- Count length N = number of enabled steps from seed to TERMINAL. If seed == TERMINAL, N = 0.
- Reset values: state IDLE, sreg '0, seed_reg '0, mode_reg 0, o_done 0, o_error 0, o_busy 0.

## Timing
- i_load sampled at edge k: o_busy = 1 and o_sreg = seed from cycle k+1.
- With i_enable held high, o_done is high in cycle k+2+N.
- One-shot: o_busy falls in the same cycle o_done rises.
- Periodic: o_done repeats every N+1 cycles; the reload cycle costs one tick.
- o_error changes in cycle k+1 after the load.
- i_stop at edge s: o_busy = 0 from cycle s+1.

## Structure
- Package lfsr_pkg holds:
  - typedef enum {IDLE, RUN} lfsr_state_t.
  - function lfsr_step(state, poly), shared by RTL and bench.
  - function lfsr_seed_for(n, poly, terminal), which steps backwards n times; used by the bench only.
- No sub-module: the step is a package function, and the existing LFSR core has no load port to reuse.

## Test plan
- Reset: assert i_reset 2 cycles -> o_sreg 0x0000, o_busy/o_done/o_error 0.
- Zero-length: load 0x0000, i_enable 1 -> o_busy high in k+1 only, o_done in k+2, o_sreg stays 0x0000.
- One step: load 0xA010, i_enable 1 -> o_sreg 0xA010 at k+1, 0x0000 at k+2, o_done at k+3. Repeat with i_enable low for 5 cycles after load -> o_done at k+8.
- Periodic: load 0xA010, i_periodic 1 -> o_done at k+3, k+5, k+7, ...; o_sreg alternates 0xA010/0x0000. i_stop ends the pulses.
- Lock-up: load 0xFFFF -> o_error 1 at k+1, o_busy 0, no o_done. Then load 0xA010 -> o_error 0 at the next cycle and the count runs.
- Stop/load collision: seed lfsr_seed_for(1000), assert i_stop and i_load together at step 10 -> IDLE, o_sreg frozen, no o_done.
